// File: rtl/smol_alu_arb.sv
// Two-requester arbiter and sequencer for the shared smolCore ALU.
// Accepts one op at a time, drives the ALU for a single cycle, then returns the result to its owner.
module smol_alu_arb #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2_or_imm,
    input  logic [4:0]  req0_op_sel,
    input  logic        req0_kill,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2_or_imm,
    input  logic [4:0]  req1_op_sel,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_data,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2_or_imm,
    output logic [4:0]  alu_op_sel,
    input  logic [31:0] alu_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        rr_last_reg, rr_last_next;
    logic [7:0]  starve_reg, starve_next;
    logic [31:0] op_a_reg, op_a_next;
    logic [31:0] op_b_reg, op_b_next;
    logic [4:0]  op_sel_reg, op_sel_next;
    logic [31:0] result_reg, result_next;

    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_rs1 [2];
    logic [31:0] req_rs2 [2];
    logic [4:0]  req_op  [2];
    logic [31:0] resp_data [2];

    logic cand0, grant_any, grant_id, starved, kill_own;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};
    assign req_rs1[0] = req0_rs1;
    assign req_rs1[1] = req1_rs1;
    assign req_rs2[0] = req0_rs2_or_imm;
    assign req_rs2[1] = req1_rs2_or_imm;
    assign req_op[0]  = req0_op_sel;
    assign req_op[1]  = req1_op_sel;

    // A flush only concerns requester 0's own op; it also keeps req0 out of arbitration.
    assign cand0    = req_valid[0] & ~req0_kill;
    assign kill_own = req0_kill & (owner_reg == 1'b0);

    always_comb begin
        grant_any = cand0 | req_valid[1];
        starved   = (starve_reg == LIMIT);
        if (PRIO_MODE == 0) begin
            grant_id = (cand0 & req_valid[1]) ? ~rr_last_reg : req_valid[1];
        end else begin
            grant_id = req_valid[1] & (starved | ~cand0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi]  = (state_reg == IDLE) && grant_any && (grant_id == 1'(gi));
            assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
            assign resp_data[gi]  = resp_valid[gi] ? result_reg : '0;
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_last_next = rr_last_reg;
        op_a_next    = op_a_reg;
        op_b_next    = op_b_reg;
        op_sel_next  = op_sel_reg;
        result_next  = result_reg;
        unique case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    op_a_next    = req_rs1[grant_id];
                    op_b_next    = req_rs2[grant_id];
                    op_sel_next  = req_op[grant_id];
                    owner_next   = grant_id;
                    rr_last_next = grant_id;
                    state_next   = EXEC;
                end
            end
            EXEC: begin
                if (kill_own) begin
                    state_next = IDLE;
                end else begin
                    result_next = alu_out;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (kill_own || resp_ready[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Starvation counter saturates at the limit so req1 keeps winning until served.
    always_comb begin
        starve_next = starve_reg;
        if (PRIO_MODE == 0 || !req_valid[1]) begin
            starve_next = '0;
        end else if (state_reg == IDLE && grant_any) begin
            if (grant_id) begin
                starve_next = '0;
            end else if (starve_reg != LIMIT) begin
                starve_next = starve_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            rr_last_reg <= 1'b1;
            starve_reg  <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            op_sel_reg  <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_last_reg <= rr_last_next;
            starve_reg  <= starve_next;
            op_a_reg    <= op_a_next;
            op_b_reg    <= op_b_next;
            op_sel_reg  <= op_sel_next;
            result_reg  <= result_next;
        end
    end

    assign alu_rs1        = (state_reg == EXEC) ? op_a_reg   : '0;
    assign alu_rs2_or_imm = (state_reg == EXEC) ? op_b_reg   : '0;
    assign alu_op_sel     = (state_reg == EXEC) ? op_sel_reg : '0;

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign resp0_valid = resp_valid[0];
    assign resp1_valid = resp_valid[1];
    assign resp0_data  = resp_data[0];
    assign resp1_data  = resp_data[1];

endmodule

// File: tb/tb_smol_alu_arb.sv
// Bench for smol_alu_arb: instance 0 runs round-robin, instance 1 fixed priority (limit 2).
// Directed vectors and sequences first, then randomized traffic against a transaction-level model.
module tb_smol_alu_arb;

    localparam int LIM = 2;

    logic        clk, rst_n;
    logic        rv   [2][2];
    logic        rdy  [2][2];
    logic [31:0] ra   [2][2];
    logic [31:0] rb   [2][2];
    logic [4:0]  rop  [2][2];
    logic        kill [2];
    logic        pv   [2][2];
    logic        prd  [2][2];
    logic [31:0] pd   [2][2];
    logic [31:0] alu_a [2];
    logic [31:0] alu_b [2];
    logic [4:0]  alu_op [2];
    logic [31:0] alu_o [2];

    int checks, failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    int grant_q [$];

    bit          m_busy [2];
    bit          m_last [2];
    bit          m_owner [2];
    int          m_since [2];
    int          m_starve;
    logic [31:0] m_a [2];
    logic [4:0]  m_op [2];
    logic [31:0] m_res [2];
    bit          acc [2][2];

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a ^ b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a << b[4:0];
            default: return b;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            smol_alu_arb #(.PRIO_MODE(gi), .STARVE_LIMIT(LIM)) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .req0_valid     (rv[gi][0]),
                .req0_ready     (rdy[gi][0]),
                .req0_rs1       (ra[gi][0]),
                .req0_rs2_or_imm(rb[gi][0]),
                .req0_op_sel    (rop[gi][0]),
                .req0_kill      (kill[gi]),
                .resp0_valid    (pv[gi][0]),
                .resp0_ready    (prd[gi][0]),
                .resp0_data     (pd[gi][0]),
                .req1_valid     (rv[gi][1]),
                .req1_ready     (rdy[gi][1]),
                .req1_rs1       (ra[gi][1]),
                .req1_rs2_or_imm(rb[gi][1]),
                .req1_op_sel    (rop[gi][1]),
                .resp1_valid    (pv[gi][1]),
                .resp1_ready    (prd[gi][1]),
                .resp1_data     (pd[gi][1]),
                .alu_rs1        (alu_a[gi]),
                .alu_rs2_or_imm (alu_b[gi]),
                .alu_op_sel     (alu_op[gi]),
                .alu_out        (alu_o[gi])
            );
            assign alu_o[gi] = alu_f(alu_a[gi], alu_b[gi], alu_op[gi]);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            kill[d] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                rv[d][i]  = 1'b0;
                ra[d][i]  = '0;
                rb[d][i]  = '0;
                rop[d][i] = '0;
                prd[d][i] = 1'b1;
            end
        end
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_quiet(input int d, input string nm);
        chk({nm, "_rdy"}, 32'({rdy[d][1], rdy[d][0]}), 32'd0);
        chk({nm, "_pv"},  32'({pv[d][1], pv[d][0]}), 32'd0);
        chk({nm, "_pd0"}, pd[d][0], 32'd0);
        chk({nm, "_pd1"}, pd[d][1], 32'd0);
        chk({nm, "_alua"}, alu_a[d], 32'd0);
        chk({nm, "_alub"}, alu_b[d], 32'd0);
        chk({nm, "_aluop"}, 32'(alu_op[d]), 32'd0);
    endtask

    task automatic set_op(input int d, input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op);
        rv[d][i]  = 1'b1;
        ra[d][i]  = a;
        rb[d][i]  = b;
        rop[d][i] = op;
    endtask

    task automatic wait_resp(input int d, input int i, input logic [31:0] exp, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!pv[d][i] && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_vld"}, 32'(pv[d][i]), 32'd1);
        chk({nm, "_other"}, 32'(pv[d][1-i]), 32'd0);
        chk({nm, "_data"}, pd[d][i], exp);
        $display("txn %s dut%0d resp%0d data=%h", nm, d, i, pd[d][i]);
        tick();
    endtask

    // Both requesters kept valid until nops grants; optional back-pressure on the first resp1.
    task automatic run_both(input int d, input int nops, input int bp);
        int ngr, bpc;
        bit busy, own;
        bit acc2 [2];
        logic [31:0] er;
        int cnt [2];
        grant_q.delete();
        ngr = 0; bpc = 0; busy = 0; own = 0; er = '0;
        prd[d][0] = 1'b1;
        prd[d][1] = (bp == 0);
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            set_op(d, i, {16'(i + 1), 16'(cnt[i])}, 32'(cnt[i] * 7 + 3), 5'(cnt[i] % 5));
            cnt[i]++;
        end
        for (int cyc = 0; cyc < 120 && !(ngr >= nops && !busy); cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                acc2[i] = 1'b0;
                if (rv[d][i] && rdy[d][i]) begin
                    grant_q.push_back(i);
                    ngr++;
                    busy = 1'b1;
                    own = 1'(i);
                    er = alu_f(ra[d][i], rb[d][i], rop[d][i]);
                    acc2[i] = 1'b1;
                    $display("txn grant dut%0d req%0d a=%h", d, i, ra[d][i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (pv[d][i]) begin
                    chk("rb_owner", 32'(i), 32'(own));
                    chk("rb_data", pd[d][i], er);
                    if (i == 1 && bp > 0 && !prd[d][1]) begin
                        bpc++;
                        chk("bp_no_grant", 32'({rdy[d][1], rdy[d][0]}), 32'd0);
                    end
                    if (prd[d][i]) busy = 1'b0;
                end
            end
            tick();
            if (bp > 0 && bpc >= bp) prd[d][1] = 1'b1;
            if (ngr >= nops) begin
                rv[d][0] = 1'b0;
                rv[d][1] = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (acc2[i]) begin
                        set_op(d, i, {16'(i + 1), 16'(cnt[i])}, 32'(cnt[i] * 7 + 3), 5'(cnt[i] % 5));
                        cnt[i]++;
                    end
                end
            end
        end
        chk("run_grants", 32'(ngr), 32'(nops));
        chk("run_idle", 32'(busy), 32'd0);
        if (bp > 0) chk("bp_cycles", 32'(bpc), 32'(bp));
    endtask

    initial begin
        bit v0, v1, w, any;
        int rr_exp [4];
        int fx_exp [6];
        checks = 0;
        failures = 0;
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 5'd0, 32'h0000_0008};
        vecs[1] = '{32'h0000_0005, 32'h0000_0003, 5'd1, 32'h0000_0002};
        vecs[2] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 5'd2, 32'hF0F0_0F0F};
        vecs[3] = '{32'hFF00_FF00, 32'h0FF0_0FF0, 5'd3, 32'h0F00_0F00};
        vecs[4] = '{32'h1234_0000, 32'h0000_5678, 5'd4, 32'h1234_5678};
        vecs[5] = '{32'h0000_0001, 32'h0000_001F, 5'd5, 32'h8000_0000};
        vecs[6] = '{32'h0000_0001, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000};
        rr_exp = '{0, 1, 0, 1};
        fx_exp = '{0, 0, 1, 0, 0, 1};

        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk_quiet(0, "reset_rr");
        chk_quiet(1, "reset_fx");
        #1;
        rst_n = 1'b1;
        tick();

        // Single ops with exact latency and ALU visibility only in EXEC.
        for (int k = 0; k < 8; k++) begin
            set_op(0, 0, vecs[k].a, vecs[k].b, vecs[k].op);
            @(negedge clk);
            chk("vec_ready", 32'(rdy[0][0]), 32'd1);
            chk("vec_alu_idle", alu_a[0], 32'd0);
            tick();
            rv[0][0] = 1'b0;
            @(negedge clk);
            chk("vec_alu_a", alu_a[0], vecs[k].a);
            chk("vec_alu_b", alu_b[0], vecs[k].b);
            chk("vec_alu_op", 32'(alu_op[0]), 32'(vecs[k].op));
            chk("vec_early", 32'(pv[0][0]), 32'd0);
            tick();
            @(negedge clk);
            chk("vec_valid", 32'(pv[0][0]), 32'd1);
            chk("vec_data", pd[0][0], vecs[k].exp);
            chk("vec_alu_resp", alu_a[0], 32'd0);
            $display("txn vec%0d op=%0d data=%h", k, vecs[k].op, pd[0][0]);
            tick();
            @(negedge clk);
            chk("vec_done", 32'(pv[0][0]), 32'd0);
            tick();
        end

        do_reset();
        run_both(0, 4, 5);
        chk("rr_count", 32'(grant_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_q.size(); k++) chk("rr_order", 32'(grant_q[k]), 32'(rr_exp[k]));

        do_reset();
        run_both(1, 6, 0);
        chk("fx_count", 32'(grant_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < grant_q.size(); k++) chk("fx_order", 32'(grant_q[k]), 32'(fx_exp[k]));

        // Kill during EXEC, with req1 waiting.
        do_reset();
        set_op(0, 0, 32'h55, 32'h1, 5'd0);
        @(negedge clk);
        chk("ke_ready0", 32'(rdy[0][0]), 32'd1);
        tick();
        rv[0][0] = 1'b0;
        kill[0] = 1'b1;
        set_op(0, 1, 32'h7, 32'h8, 5'd0);
        @(negedge clk);
        chk("ke_exec_alu", alu_a[0], 32'h55);
        chk("ke_exec_rdy", 32'({rdy[0][1], rdy[0][0]}), 32'd0);
        tick();
        kill[0] = 1'b0;
        @(negedge clk);
        chk("ke_no_resp0", 32'(pv[0][0]), 32'd0);
        chk("ke_grant1", 32'(rdy[0][1]), 32'd1);
        tick();
        rv[0][1] = 1'b0;
        wait_resp(0, 1, 32'hF, "ke_r1");

        // Kill during RESP while requester 0 back-pressures.
        do_reset();
        prd[0][0] = 1'b0;
        set_op(0, 0, 32'h9, 32'h4, 5'd1);
        @(negedge clk);
        chk("kr_ready0", 32'(rdy[0][0]), 32'd1);
        tick();
        rv[0][0] = 1'b0;
        tick();
        @(negedge clk);
        chk("kr_valid", 32'(pv[0][0]), 32'd1);
        chk("kr_data", pd[0][0], 32'h5);
        tick();
        kill[0] = 1'b1;
        @(negedge clk);
        chk("kr_still", 32'(pv[0][0]), 32'd1);
        tick();
        kill[0] = 1'b0;
        @(negedge clk);
        chk("kr_dropped", 32'(pv[0][0]), 32'd0);
        tick();
        prd[0][0] = 1'b1;
        set_op(0, 1, 32'h100, 32'h23, 5'd4);
        @(negedge clk);
        chk("kr_idle_grant1", 32'(rdy[0][1]), 32'd1);
        tick();
        rv[0][1] = 1'b0;
        wait_resp(0, 1, 32'h123, "kr_r1");

        // Kill in IDLE blocks requester 0 for that cycle.
        set_op(0, 0, 32'h20, 32'h2, 5'd5);
        kill[0] = 1'b1;
        @(negedge clk);
        chk("ki_blocked", 32'(rdy[0][0]), 32'd0);
        tick();
        kill[0] = 1'b0;
        @(negedge clk);
        chk("ki_granted", 32'(rdy[0][0]), 32'd1);
        tick();
        rv[0][0] = 1'b0;
        wait_resp(0, 0, 32'h80, "ki_r0");

        // Kill is ignored while requester 1 owns the ALU.
        do_reset();
        set_op(0, 1, 32'h1111_1111, 32'h2222_2222, 5'd0);
        @(negedge clk);
        chk("k1_ready1", 32'(rdy[0][1]), 32'd1);
        tick();
        rv[0][1] = 1'b0;
        kill[0] = 1'b1;
        @(negedge clk);
        chk("k1_exec_alu", alu_a[0], 32'h1111_1111);
        tick();
        @(negedge clk);
        chk("k1_valid", 32'(pv[0][1]), 32'd1);
        chk("k1_data", pd[0][1], 32'h3333_3333);
        tick();
        kill[0] = 1'b0;
        @(negedge clk);
        chk("k1_done", 32'(pv[0][1]), 32'd0);
        tick();

        // Asynchronous reset in the middle of EXEC.
        do_reset();
        set_op(0, 0, 32'hA5A5_A5A5, 32'h1, 5'd4);
        @(negedge clk);
        chk("ar_ready0", 32'(rdy[0][0]), 32'd1);
        tick();
        rv[0][0] = 1'b0;
        @(negedge clk);
        chk("ar_exec_alu", alu_a[0], 32'hA5A5_A5A5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet(0, "ar_async");
        #3;
        rst_n = 1'b1;
        set_op(0, 0, 32'h3, 32'h4, 5'd0);
        set_op(0, 1, 32'h6, 32'h7, 5'd0);
        @(negedge clk);
        chk("ar_tie", 32'({rdy[0][1], rdy[0][0]}), 32'd1);
        tick();
        rv[0][0] = 1'b0;
        rv[0][1] = 1'b0;
        wait_resp(0, 0, 32'h7, "ar_r0");

        // Randomized traffic on both instances against the transaction model.
        do_reset();
        m_starve = 0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_last[d] = 1; m_owner[d] = 0; m_since[d] = 0;
            m_a[d] = '0; m_op[d] = '0; m_res[d] = '0;
            for (int i = 0; i < 2; i++) acc[d][i] = 0;
        end
        for (int cyc = 0; cyc < 700; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 2; i++) begin
                    if (acc[d][i] || !rv[d][i]) begin
                        rv[d][i]  = ($urandom % 4) != 0;
                        ra[d][i]  = $urandom;
                        rb[d][i]  = $urandom;
                        rop[d][i] = 5'($urandom_range(0, 7));
                    end
                    prd[d][i] = ($urandom % 3) != 0;
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                v0 = rv[d][0];
                v1 = rv[d][1];
                if (d == 0) w = (v0 && v1) ? !m_last[0] : v1;
                else        w = v1 && (m_starve == LIM || !v0);
                any = (v0 || v1) && !m_busy[d];
                chk("rnd_ready", 32'({rdy[d][1], rdy[d][0]}), 32'({any && w, any && !w}));
                for (int i = 0; i < 2; i++) begin
                    bit ev;
                    ev = m_busy[d] && m_since[d] >= 2 && (m_owner[d] == 1'(i));
                    chk("rnd_resp_valid", 32'(pv[d][i]), 32'(ev));
                    if (ev) chk("rnd_resp_data", pd[d][i], m_res[d]);
                end
                chk("rnd_alu_a", alu_a[d], (m_busy[d] && m_since[d] == 1) ? m_a[d] : 32'd0);
                chk("rnd_alu_op", 32'(alu_op[d]), (m_busy[d] && m_since[d] == 1) ? 32'(m_op[d]) : 32'd0);
                acc[d][0] = 0;
                acc[d][1] = 0;
                if (any) begin
                    acc[d][w] = 1;
                    m_busy[d] = 1;
                    m_since[d] = 1;
                    m_owner[d] = w;
                    m_last[d] = w;
                    m_a[d] = ra[d][w];
                    m_op[d] = rop[d][w];
                    m_res[d] = alu_f(ra[d][w], rb[d][w], rop[d][w]);
                    $display("txn rnd dut%0d req%0d a=%h op=%0d", d, w, ra[d][w], rop[d][w]);
                end else if (m_busy[d]) begin
                    if (m_since[d] >= 2 && prd[d][m_owner[d]]) m_busy[d] = 0;
                    else m_since[d]++;
                end
                if (d == 1) begin
                    if (!v1) m_starve = 0;
                    else if (any) m_starve = w ? 0 : ((m_starve < LIM) ? m_starve + 1 : m_starve);
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smol_alu_arb.md
Name: smol_alu_arb

Overview:
Two-requester arbiter and sequencer for the shared smolCore integer ALU (32-bit operands, 5-bit op select, combinational 32-bit result).
- Requester 0 is the main pipeline execute path; requester 1 is the branch/address-generation unit.
- The block arbitrates, latches operands, drives the ALU for one cycle, then registers and returns the result to the owning requester over a valid/ready handshake.

Parameters:
PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority to requester 0 with starvation guard
STARVE_LIMIT, 8, fixed mode only: consecutive cycles req1 may wait while req0 wins before req1 is forced (range 1..255)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle when high with valid
req0_rs1  in  32  operand A
req0_rs2_or_imm  in  32  operand B / immediate
req0_op_sel  in  5  ALU op code, passed through unmodified
req0_kill  in  1  cancel requester 0's in-flight op (pipeline flush)
resp0_valid  out  1  result ready for requester 0
resp0_ready  in  1  requester 0 takes result
resp0_data  out  32  result
req1_valid, req1_ready, req1_rs1, req1_rs2_or_imm, req1_op_sel, resp1_valid, resp1_ready, resp1_data: same as requester 0 (no kill)
alu_rs1  out  32  to ALU rs1
alu_rs2_or_imm  out  32  to ALU rs2_or_imm
alu_op_sel  out  5  to ALU op_sel
alu_out  in  32  from ALU, combinational

Behaviour:
- Reset (async assert, sync release): state IDLE; req*_ready=0 except per IDLE rule below; resp*_valid=0; resp*_data=0; alu_* outputs=0; owner=0; rr_last=1 (req0 wins the first tie); starve_cnt=0.
- FSM states:
  - IDLE: winner computed combinationally from valids; only the winner's req_ready=1, the other 0; with no valid, both ready=0. Handshake (valid&ready) latches rs1, rs2_or_imm, op_sel and owner id into operand registers, then goes to EXEC.
  - EXEC: alu_* driven from operand registers. At the cycle end alu_out is captured into the result register, then goes to RESP.
  - RESP: resp<owner>_valid=1, resp<owner>_data=result. On resp_ready, goes to IDLE. No new request is accepted in EXEC or RESP (req*_ready=0).
- alu_* outputs are 0 in IDLE and RESP; they are non-zero only in EXEC.
- Latency: request accepted at edge T; resp_valid high from edge T+2. Peak throughput is 1 op / 3 cycles.
- resp_valid and data stay stable until the handshake; resp_ready while resp_valid=0 is ignored.
- Round-robin (PRIO_MODE=0): when both are valid, grant the requester not granted last; rr_last updates only on accept.
- Fixed mode (PRIO_MODE=1):
  - req0 wins ties.
  - starve_cnt increments each IDLE cycle in which req1_valid=1 and req0 is granted; it resets to 0 on a req1 grant or when req1_valid=0.
  - When starve_cnt==STARVE_LIMIT, req1 wins over req0.
  - starve_cnt saturates and never wraps.
- Kill, with req0_kill=1 while owner=0:
  - In EXEC: the result is discarded and the FSM goes to IDLE; resp0_valid never rises.
  - In RESP: resp0_valid drops next cycle and the FSM goes to IDLE, even without resp0_ready.
  - In IDLE: the kill blocks req0 from being granted that cycle.
  - Kill is ignored when owner=1.
- Widths: no arithmetic is done on data; the 32-bit operands and 5-bit op are forwarded bit-exact.
- Reset mid-operation drops the in-flight op with no response.

Test Plan:
1. Single op: req0 rs1=0x0000_0005, rs2=0x0000_0003, op=ADD code; ALU model returns sum -> req0_ready=1 at T, resp0_valid from T+2 with resp0_data=0x0000_0008, alu_* zero outside EXEC.
2. Round-robin, PRIO_MODE=0: both valid continuously for 4 ops -> grant order 0,1,0,1; each resp goes only to its owner; back-pressure resp1_ready=0 for 5 cycles holds resp1_valid/data stable and blocks new grants.
3. Fixed priority, STARVE_LIMIT=2: req0 and req1 both valid continuously -> grants 0,0,1,0,0,1; starve_cnt resets after each req1 grant.
4. Kill: req0 accepted, req0_kill=1 in EXEC -> no resp0_valid, FSM IDLE next cycle, pending req1 granted the following cycle. Repeat with kill in RESP under resp0_ready=0 -> resp0_valid drops.
5. Kill with owner=1: req1 op in flight, req0_kill pulse -> resp1 delivered normally with the correct value.
6. Async reset asserted mid-EXEC (not on a clock edge) -> all outputs 0 immediately; after release, first tie is granted to req0.
